// File: rtl/axi_burst_pkg.sv
// Shared definitions for the AXI-style burst master: default widths,
// FSM state encodings and response codes.
package axi_burst_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ID_W   = 4;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_RESP_W = 2;

  // Read engine states
  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Write engine states
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_e;

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter for one burst: cleared on load, advanced on inc, and
// flags when the current beat index equals the burst length field.
module axi_beat_counter import axi_burst_pkg::*; #(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic             is_last
);

  logic [LEN_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign is_last = (count == len);

endmodule

// File: rtl/axi_burst_master.sv
// AXI-style burst master with independent read (AR/R) and write (AW/W/B)
// engines, each accepting one command at a time from a simple user side.
module axi_burst_master import axi_burst_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RESP_W = DEF_RESP_W,
  parameter int MAXB   = 2**LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  // read command / beat return
  input  logic                   rd_cmd_valid,
  output logic                   rd_cmd_ready,
  input  logic [ADDR_W-1:0]      rd_cmd_addr,
  input  logic [LEN_W-1:0]       rd_cmd_len,
  input  logic [ID_W-1:0]        rd_cmd_id,
  output logic                   rd_beat_valid,
  output logic [DATA_W-1:0]      rd_beat_data,
  output logic [RESP_W-1:0]      rd_beat_resp,
  output logic                   rd_beat_last,
  output logic                   rd_err,
  // write command / completion
  input  logic                   wr_cmd_valid,
  output logic                   wr_cmd_ready,
  input  logic [ADDR_W-1:0]      wr_cmd_addr,
  input  logic [LEN_W-1:0]       wr_cmd_len,
  input  logic [ID_W-1:0]        wr_cmd_id,
  input  logic [MAXB*DATA_W-1:0] wr_cmd_data,
  output logic                   wr_done,
  output logic [RESP_W-1:0]      wr_done_resp,
  output logic                   wr_err,
  // AR / R
  output logic                   ARVALID,
  input  logic                   ARREADY,
  output logic [ADDR_W-1:0]      ARADDR,
  output logic [LEN_W-1:0]       ARLEN,
  output logic [ID_W-1:0]        ARID,
  input  logic                   RVALID,
  output logic                   RREADY,
  input  logic [DATA_W-1:0]      RDATA,
  input  logic [RESP_W-1:0]      RRESP,
  input  logic                   RLAST,
  input  logic [ID_W-1:0]        RID,
  // AW / W / B
  output logic                   AWVALID,
  input  logic                   AWREADY,
  output logic [ADDR_W-1:0]      AWADDR,
  output logic [LEN_W-1:0]       AWLEN,
  output logic [ID_W-1:0]        AWID,
  output logic                   WVALID,
  input  logic                   WREADY,
  output logic [DATA_W-1:0]      WDATA,
  output logic                   WLAST,
  input  logic                   BVALID,
  output logic                   BREADY,
  input  logic [RESP_W-1:0]      BRESP,
  input  logic [ID_W-1:0]        BID
);

  logic [1:0]             r_state, w_state;
  logic                   r_is_last, w_is_last;
  logic                   r_load, r_inc, r_beat_hs, r_end;
  logic                   w_load, w_inc;
  logic [MAXB*DATA_W-1:0] w_data_q;

  // ARLEN/ARID and AWLEN/AWID double as the latched command fields.
  assign r_beat_hs = (r_state == R_DATA) && RVALID && RREADY;
  assign r_end     = RLAST || r_is_last;
  assign r_load    = (r_state == R_IDLE) && rd_cmd_valid;
  assign r_inc     = r_beat_hs && !r_end;

  // Write counter holds the index of the next beat to load into WDATA.
  assign w_load = (w_state == W_IDLE) && wr_cmd_valid;
  assign w_inc  = !w_is_last &&
                  (((w_state == W_ADDR) && AWREADY) || ((w_state == W_DATA) && WREADY));

  axi_beat_counter #(.LEN_W(LEN_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .load(r_load), .inc(r_inc), .len(ARLEN), .is_last(r_is_last)
  );

  axi_beat_counter #(.LEN_W(LEN_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .load(w_load), .inc(w_inc), .len(AWLEN), .is_last(w_is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      rd_cmd_ready  <= 1'b1;
      ARVALID       <= 1'b0;
      ARADDR        <= '0;
      ARLEN         <= '0;
      ARID          <= '0;
      RREADY        <= 1'b0;
      rd_beat_valid <= 1'b0;
      rd_beat_data  <= '0;
      rd_beat_resp  <= '0;
      rd_beat_last  <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      rd_beat_valid <= 1'b0;
      case (r_state)
        R_IDLE: if (rd_cmd_valid) begin
          ARADDR       <= rd_cmd_addr;
          ARLEN        <= rd_cmd_len;
          ARID         <= rd_cmd_id;
          ARVALID      <= 1'b1;
          rd_err       <= 1'b0;
          rd_cmd_ready <= 1'b0;
          r_state      <= R_ADDR;
        end
        R_ADDR: if (ARREADY) begin
          ARVALID <= 1'b0;
          RREADY  <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: if (r_beat_hs) begin
          rd_beat_valid <= 1'b1;
          rd_beat_data  <= RDATA;
          rd_beat_resp  <= RRESP;
          rd_beat_last  <= RLAST;
          if ((RLAST != r_is_last) || (RID != ARID)) rd_err <= 1'b1;
          if (r_end) begin
            RREADY       <= 1'b0;
            rd_cmd_ready <= 1'b1;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      wr_cmd_ready <= 1'b1;
      AWVALID      <= 1'b0;
      AWADDR       <= '0;
      AWLEN        <= '0;
      AWID         <= '0;
      WVALID       <= 1'b0;
      WDATA        <= '0;
      WLAST        <= 1'b0;
      BREADY       <= 1'b0;
      wr_done      <= 1'b0;
      wr_done_resp <= '0;
      wr_err       <= 1'b0;
      // NOTE: the beat store is ordinary flops, not a RAM, so it takes the reset like everything else.
      w_data_q     <= '0;
    end else begin
      wr_done <= 1'b0;
      case (w_state)
        W_IDLE: if (wr_cmd_valid) begin
          AWADDR       <= wr_cmd_addr;
          AWLEN        <= wr_cmd_len;
          AWID         <= wr_cmd_id;
          w_data_q     <= wr_cmd_data;
          AWVALID      <= 1'b1;
          wr_cmd_ready <= 1'b0;
          w_state      <= W_ADDR;
        end
        W_ADDR: if (AWREADY) begin
          AWVALID  <= 1'b0;
          WVALID   <= 1'b1;
          WDATA    <= w_data_q[DATA_W-1:0];
          w_data_q <= w_data_q >> DATA_W;
          WLAST    <= w_is_last;
          w_state  <= W_DATA;
        end
        W_DATA: if (WREADY) begin
          if (WLAST) begin
            WVALID  <= 1'b0;
            WLAST   <= 1'b0;
            BREADY  <= 1'b1;
            w_state <= W_RESP;
          end else begin
            WDATA    <= w_data_q[DATA_W-1:0];
            w_data_q <= w_data_q >> DATA_W;
            WLAST    <= w_is_last;
          end
        end
        W_RESP: if (BVALID) begin
          wr_done      <= 1'b1;
          wr_done_resp <= BRESP;
          wr_err       <= (BID != AWID);
          BREADY       <= 1'b0;
          wr_cmd_ready <= 1'b1;
          w_state      <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a slave model driven step by step,
// with a scoreboard for read beats, write beats and write responses.
module tb_axi_burst_master;
  import axi_burst_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int RESP_W = 2;
  localparam int MAXB   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_cmd_valid = 0, wr_cmd_valid = 0;
  logic [ADDR_W-1:0] rd_cmd_addr = '0, wr_cmd_addr = '0;
  logic [LEN_W-1:0]  rd_cmd_len = '0, wr_cmd_len = '0;
  logic [ID_W-1:0]   rd_cmd_id = '0, wr_cmd_id = '0;
  logic [MAXB*DATA_W-1:0] wr_cmd_data = '0;
  logic rd_cmd_ready, rd_beat_valid, rd_beat_last, rd_err;
  logic [DATA_W-1:0] rd_beat_data;
  logic [RESP_W-1:0] rd_beat_resp, wr_done_resp;
  logic wr_cmd_ready, wr_done, wr_err;
  logic ARVALID, ARREADY = 0, RVALID = 0, RREADY, RLAST = 0;
  logic [ADDR_W-1:0] ARADDR, AWADDR;
  logic [LEN_W-1:0]  ARLEN, AWLEN;
  logic [ID_W-1:0]   ARID, AWID, RID = '0, BID = '0;
  logic [DATA_W-1:0] RDATA = '0, WDATA;
  logic [RESP_W-1:0] RRESP = '0, BRESP = '0;
  logic AWVALID, AWREADY = 0, WVALID, WREADY = 0, WLAST, BVALID = 0, BREADY;

  int total = 0;
  int bad   = 0;
  logic [63:0] rd_q[$];
  logic [63:0] w_q[$];
  logic [63:0] b_q[$];

  axi_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .RESP_W(RESP_W), .MAXB(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_cmd_id(rd_cmd_id),
    .rd_beat_valid(rd_beat_valid), .rd_beat_data(rd_beat_data), .rd_beat_resp(rd_beat_resp),
    .rd_beat_last(rd_beat_last), .rd_err(rd_err),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_len(wr_cmd_len), .wr_cmd_id(wr_cmd_id), .wr_cmd_data(wr_cmd_data),
    .wr_done(wr_done), .wr_done_resp(wr_done_resp), .wr_err(wr_err),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare DUT outputs on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_beat_valid) begin
        check("rd_q_nonempty", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) check("rd_beat", {53'd0, rd_beat_data, rd_beat_resp, rd_beat_last}, rd_q.pop_front());
      end
      if (wr_done) begin
        check("b_q_nonempty", 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) check("wr_done", {61'd0, wr_done_resp, wr_err}, b_q.pop_front());
      end
      if (WVALID) begin
        check("w_order", 64'(AWVALID), 64'd0);
        check("w_q_nonempty", 64'(w_q.size() != 0), 64'd1);
        if (w_q.size() != 0) begin
          check("w_beat", {55'd0, WDATA, WLAST}, w_q[0]);
          if (WREADY) void'(w_q.pop_front());
        end
      end
    end
  end

  task automatic set_rd(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id);
    rd_cmd_valid = 1'b1; rd_cmd_addr = addr; rd_cmd_len = len; rd_cmd_id = id;
  endtask

  task automatic set_wr(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                        input logic [7:0] base, input logic [7:0] step);
    logic [MAXB*DATA_W-1:0] d;
    logic [7:0] v;
    d = {MAXB{8'hEE}};
    for (int k = 0; k <= int'(len); k++) begin
      v = base + 8'(k) * step;
      d[k*DATA_W +: DATA_W] = v;
      w_q.push_back({55'd0, v, (k == int'(len))});
    end
    wr_cmd_valid = 1'b1; wr_cmd_addr = addr; wr_cmd_len = len; wr_cmd_id = id; wr_cmd_data = d;
  endtask

  task automatic issue_rd(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id);
    set_rd(addr, len, id);
    tick();
    rd_cmd_valid = 1'b0;
    check("rd_cmd_ready_busy", rd_cmd_ready, 0);
    check("araddr", {ARVALID, ARADDR, ARLEN, ARID}, {1'b1, addr, len, id});
  endtask

  task automatic issue_wr(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic [7:0] base, input logic [7:0] step);
    set_wr(addr, len, id, base, step);
    tick();
    wr_cmd_valid = 1'b0;
    check("wr_cmd_ready_busy", wr_cmd_ready, 0);
    check("awaddr", {AWVALID, AWADDR, AWLEN, AWID}, {1'b1, addr, len, id});
  endtask

  // Read slave: AR accepted after ar_delay cycles, then nbeats of base+k with RLAST on last_at.
  task automatic rd_slave(input int ar_delay, input int nbeats, input int last_at,
                          input logic [7:0] base, input logic [3:0] rid, input logic exp_err);
    for (int i = 0; i < ar_delay; i++) begin
      tick();
      check("arvalid_hold", ARVALID, 1);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    check("arvalid_drop", ARVALID, 0);
    check("rready_up", RREADY, 1);
    for (int k = 0; k < nbeats; k++) begin
      RVALID = 1'b1; RDATA = base + 8'(k); RRESP = OKAY; RLAST = (k == last_at); RID = rid;
      rd_q.push_back({53'd0, RDATA, 2'b00, RLAST});
      tick();
    end
    RVALID = 1'b0; RLAST = 1'b0;
    check("rd_err", rd_err, exp_err);
    check("rd_idle", {rd_cmd_ready, RREADY}, 2'b10);
    tick();
    check("rd_q_drained", rd_q.size(), 0);
  endtask

  // Write slave: AW accepted next cycle, WREADY from pat (LSB first, then 1), then B.
  task automatic wr_slave(input logic [15:0] pat, input int plen, input logic [1:0] bresp,
                          input logic [3:0] bid, input logic exp_err);
    int n;
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    check("wvalid_after_aw", {AWVALID, WVALID}, 2'b01);
    n = 0;
    while (WVALID && n < 100) begin
      WREADY = (n < plen) ? pat[n] : 1'b1;
      tick();
      n++;
    end
    WREADY = 1'b0;
    check("w_drained", {WVALID, BREADY}, 2'b01);
    BVALID = 1'b1; BRESP = bresp; BID = bid;
    b_q.push_back({61'd0, bresp, exp_err});
    tick();
    BVALID = 1'b0;
    check("wr_idle", {wr_cmd_ready, BREADY}, 2'b10);
    tick();
    check("w_q_drained", w_q.size() + b_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_ready", {rd_cmd_ready, wr_cmd_ready}, 2'b11);
    check("rst_valids", {ARVALID, RREADY, AWVALID, WVALID, BREADY, rd_beat_valid, wr_done}, 0);
    check("rst_errs", {rd_err, wr_err, WDATA, WLAST}, 0);
    rst = 1'b0;
    tick();

    // Single read, ARREADY after 2 cycles
    issue_rd(8'h3C, 4'd0, 4'd5);
    rd_slave(2, 1, 0, 8'hA5, 4'd5, 1'b0);

    // 4-beat write with WREADY 1,0,1,0,1,1
    issue_wr(8'h80, 4'd3, 4'd6, 8'h11, 8'h11);
    wr_slave(16'b0000_0000_0011_0101, 6, OKAY, 4'd6, 1'b0);

    // Early RLAST on beat 2 of 4, then a new command clears rd_err
    issue_rd(8'h10, 4'd3, 4'd2);
    rd_slave(0, 3, 2, 8'h30, 4'd2, 1'b1);
    issue_rd(8'h20, 4'd0, 4'd1);
    check("rd_err_cleared", rd_err, 0);
    rd_slave(1, 1, 0, 8'h5A, 4'd1, 1'b0);

    // RID mismatch
    issue_rd(8'h24, 4'd0, 4'd4);
    rd_slave(0, 1, 0, 8'h77, 4'd9, 1'b1);

    // Concurrent read and write accepted in the same cycle
    set_rd(8'h44, 4'd1, 4'd3);
    set_wr(8'h88, 4'd1, 4'd8, 8'hC0, 8'h01);
    tick();
    rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0;
    check("both_busy", {rd_cmd_ready, wr_cmd_ready, ARVALID, AWVALID}, 4'b0011);
    fork
      rd_slave(1, 2, 1, 8'h60, 4'd3, 1'b0);
      wr_slave(16'b10, 2, OKAY, 4'd8, 1'b0);
    join

    // BID mismatch with SLVERR
    issue_wr(8'h90, 4'd0, 4'd2, 8'h3E, 8'h00);
    wr_slave(16'h0, 0, SLVERR, 4'd7, 1'b1);

    // Reset in the middle of a write burst, then a fresh write
    issue_wr(8'h50, 4'd3, 4'd3, 8'hA0, 8'h01);
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    WREADY = 1'b1;
    tick();
    WREADY = 1'b0;
    rst = 1'b1;
    w_q.delete();
    tick();
    check("rst_mid_w", {WVALID, BREADY, AWVALID, WLAST}, 0);
    check("rst_mid_data", {WDATA, AWADDR, AWLEN}, 0);
    check("rst_mid_ready", {wr_cmd_ready, rd_cmd_ready}, 2'b11);
    rst = 1'b0;
    tick();
    issue_wr(8'h54, 4'd1, 4'd1, 8'h0F, 8'h10);
    wr_slave(16'h0, 0, OKAY, 4'd1, 1'b0);

    // Maximum-length bursts
    issue_wr(8'hF0, 4'd15, 4'd15, 8'h01, 8'h03);
    wr_slave(16'h0, 0, EXOKAY, 4'd15, 1'b0);
    issue_rd(8'hE0, 4'd15, 4'd11);
    rd_slave(0, 16, 15, 8'h40, 4'd11, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
